// File: rtl/gx4000_cart_fetch.sv
// GX4000 cartridge fetch: maps Z80 ROM reads onto a 19-bit cartridge memory with WAIT handshake.
// Optional one-entry read cache enabled by defining GX4000_CART_CACHE_EN.
module gx4000_cart_fetch #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic        cart_download,
  output logic [7:0]  cpu_dout,
  output logic        cpu_wait,
  output logic [18:0] mem_addr,
  output logic        mem_rd,
  input  logic        mem_ack,
  input  logic [7:0]  mem_q,
  output logic [4:0]  bank_sel,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic        rd_prev;
  logic        wr_prev;
  logic [7:0]  cnt;
  logic        rd_edge;
  logic        wr_edge;
  logic        mapped;
  logic [18:0] req_addr;
  logic        unused_bits;

  assign rd_edge     = cpu_rd & ~rd_prev;
  assign wr_edge     = cpu_wr & ~wr_prev;
  assign mapped      = (cpu_addr[15:14] == 2'b00) || (cpu_addr[15:14] == 2'b11);
  assign req_addr    = {(cpu_addr[15] ? bank_sel : 5'd0), cpu_addr[13:0]};
  assign unused_bits = ^cpu_data[7:5];

`ifdef GX4000_CART_CACHE_EN
  logic [18:0] cache_tag;
  logic [7:0]  cache_data;
  logic        cache_vld;
  logic        cache_hit;

  assign cache_hit = cache_vld && (cache_tag == req_addr);
`endif

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state       <= IDLE;
      rd_prev     <= 1'b0;
      wr_prev     <= 1'b0;
      cnt         <= 8'd0;
      cpu_dout    <= 8'hFF;
      cpu_wait    <= 1'b0;
      mem_rd      <= 1'b0;
      mem_addr    <= 19'd0;
      bank_sel    <= 5'd0;
      timeout_err <= 1'b0;
`ifdef GX4000_CART_CACHE_EN
      cache_vld   <= 1'b0;
`endif
    end else begin
      rd_prev <= cpu_rd;
      wr_prev <= cpu_wr;

      // Bank register is independent of the FSM; the in-flight mem_addr is already latched.
      if (wr_edge && (cpu_addr[15:8] == 8'hDF))
        bank_sel <= cpu_data[4:0];

      if (cart_download) begin
        state    <= IDLE;
        mem_rd   <= 1'b0;
        cpu_wait <= 1'b0;
`ifdef GX4000_CART_CACHE_EN
        cache_vld <= 1'b0;
`endif
        if ((state == IDLE) && rd_edge && mapped)
          cpu_dout <= 8'hFF;
      end else begin
        case (state)
          IDLE: begin
            if (rd_edge && mapped) begin
              mem_addr <= req_addr;
`ifdef GX4000_CART_CACHE_EN
              if (cache_hit) begin
                cpu_dout <= cache_data;
                state    <= DONE;
              end else begin
                mem_rd   <= 1'b1;
                cpu_wait <= 1'b1;
                cnt      <= 8'd0;
                state    <= REQ;
              end
`else
              mem_rd   <= 1'b1;
              cpu_wait <= 1'b1;
              cnt      <= 8'd0;
              state    <= REQ;
`endif
            end
          end
          REQ: begin
            // Ack takes priority over a timeout landing in the same cycle.
            if (mem_ack) begin
              cpu_dout <= mem_q;
              mem_rd   <= 1'b0;
              cpu_wait <= 1'b0;
              state    <= DONE;
`ifdef GX4000_CART_CACHE_EN
              cache_tag  <= mem_addr;
              cache_data <= mem_q;
              cache_vld  <= 1'b1;
`endif
            end else if (cnt == CNT_LAST) begin
              cpu_dout    <= 8'hFF;
              timeout_err <= 1'b1;
              mem_rd      <= 1'b0;
              cpu_wait    <= 1'b0;
              state       <= DONE;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          DONE: begin
            if (!cpu_rd)
              state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gx4000_cart_fetch.sv
// Self-checking bench for gx4000_cart_fetch: directed scenarios plus randomized reads against a transaction-level model.
module tb_gx4000_cart_fetch;

  localparam int TO = 8;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        cpu_rd;
  logic        cpu_wr;
  logic        cart_download;
  logic [7:0]  cpu_dout;
  logic        cpu_wait;
  logic [18:0] mem_addr;
  logic        mem_rd;
  logic        mem_ack;
  logic [7:0]  mem_q;
  logic [4:0]  bank_sel;
  logic        timeout_err;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  logic [4:0]  m_bank;
  logic [7:0]  m_dout;
  logic        m_terr;
  logic        c_vld;
  logic [18:0] c_tag;
  logic [7:0]  c_data;

  gx4000_cart_fetch #(.TIMEOUT(TO)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cart_download(cart_download), .cpu_dout(cpu_dout),
    .cpu_wait(cpu_wait), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_ack(mem_ack),
    .mem_q(mem_q), .bank_sel(bank_sel), .timeout_err(timeout_err)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic model_reset();
    m_bank = 5'd0;
    m_dout = 8'hFF;
    m_terr = 1'b0;
    c_vld  = 1'b0;
    c_tag  = '0;
    c_data = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; cpu_addr = 16'h0; cpu_data = 8'h0; cpu_rd = 1'b0; cpu_wr = 1'b0;
    cart_download = 1'b0; mem_ack = 1'b0; mem_q = 8'h0;
    model_reset();
    repeat (3) @(negedge clk_sys);
    n_cmp++;
    if ({cpu_dout, cpu_wait, mem_rd, mem_addr, bank_sel, timeout_err} !==
        {8'hFF, 1'b0, 1'b0, 19'd0, 5'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got dout=%h wait=%b rd=%b addr=%h bank=%h terr=%b required FF 0 0 00000 00 0",
               cpu_dout, cpu_wait, mem_rd, mem_addr, bank_sel, timeout_err);
    end
    reset_n = 1'b1;
    @(negedge clk_sys);
  endtask

  task automatic bank_write(input logic [15:0] a, input logic [7:0] v);
    @(negedge clk_sys);
    cpu_addr = a; cpu_data = v; cpu_wr = 1'b1;
    @(negedge clk_sys);
    cpu_wr = 1'b0;
    if (a[15:8] == 8'hDF) m_bank = v[4:0];
    n_cmp++;
    if (bank_sel !== m_bank) begin
      n_fail++;
      $display("FAIL bank_write: got %h required %h", bank_sel, m_bank);
    end
  endtask

  // One CPU read; d = ack delay in cycles after the first request cycle (d >= TO means never).
  task automatic do_read(input logic [15:0] a, input int d, input logic [7:0] q);
    logic [18:0] ea;
    logic        mapped;
    logic        hit;
    int          exp_w;
    int          wcnt;
    int          rdcnt;
    mapped = (a[15:14] == 2'b00) || (a[15:14] == 2'b11);
    ea     = {(a[15] ? m_bank : 5'd0), a[13:0]};
    hit    = 1'b0;
`ifdef GX4000_CART_CACHE_EN
    hit = mapped && c_vld && (c_tag == ea);
`endif
    if (!mapped || hit) exp_w = 0;
    else exp_w = (d < TO) ? d + 1 : TO;
    @(negedge clk_sys);
    cpu_addr = a; cpu_rd = 1'b1;
    wcnt = 0; rdcnt = 0;
    for (int k = 1; k <= TO + 4; k++) begin
      @(negedge clk_sys);
      mem_ack = 1'b0;
      if (cpu_wait) wcnt++;
      if (mem_rd) rdcnt++;
      if (k == 1 && exp_w > 0) begin
        n_cmp++;
        if (mem_addr !== ea) begin
          n_fail++;
          $display("FAIL mem_addr %h: got %h required %h", a, mem_addr, ea);
        end
      end
      if (k == 1 && hit) begin
        n_cmp++;
        if (cpu_dout !== c_data) begin
          n_fail++;
          $display("FAIL cache_hit_data %h: got %h required %h", a, cpu_dout, c_data);
        end
      end
      if (exp_w > 0 && d < TO && k == d + 1) begin
        mem_ack = 1'b1; mem_q = q;
      end else if (k == exp_w + 2) begin
        mem_ack = 1'b1; mem_q = ~q;   // stray ack outside a request
      end
    end
    mem_ack = 1'b0;
    if (mapped && !hit) begin
      if (d < TO) begin
        m_dout = q;
        c_vld = 1'b1; c_tag = ea; c_data = q;
      end else begin
        m_dout = 8'hFF;
        m_terr = 1'b1;
      end
    end else if (hit) begin
      m_dout = c_data;
    end
    n_cmp++;
    if (wcnt !== exp_w || rdcnt !== exp_w) begin
      n_fail++;
      $display("FAIL wait_len %h d=%0d: got wait=%0d rd=%0d required %0d", a, d, wcnt, rdcnt, exp_w);
    end
    n_cmp++;
    if (cpu_dout !== m_dout || timeout_err !== m_terr) begin
      n_fail++;
      $display("FAIL read_result %h d=%0d: got dout=%h terr=%b required dout=%h terr=%b",
               a, d, cpu_dout, timeout_err, m_dout, m_terr);
    end
    @(negedge clk_sys);
    cpu_rd = 1'b0;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic test_write_during_fetch();
    logic [18:0] ea;
    ea = {m_bank, 14'h0456};
    @(negedge clk_sys);
    cpu_addr = 16'hC456; cpu_rd = 1'b1;
    @(negedge clk_sys);
    cpu_addr = 16'hDF00; cpu_data = 8'h13; cpu_wr = 1'b1;
    @(negedge clk_sys);
    cpu_wr = 1'b0;
    m_bank = 5'h13;
    n_cmp++;
    if (bank_sel !== m_bank || mem_addr !== ea || mem_rd !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_during_fetch: got bank=%h addr=%h rd=%b required bank=%h addr=%h rd=1",
               bank_sel, mem_addr, mem_rd, m_bank, ea);
    end
    mem_ack = 1'b1; mem_q = 8'hC3;
    @(negedge clk_sys);
    mem_ack = 1'b0;
    m_dout = 8'hC3; c_vld = 1'b1; c_tag = ea; c_data = 8'hC3;
    n_cmp++;
    if (cpu_dout !== m_dout || cpu_wait !== 1'b0 || mem_rd !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_during_fetch_data: got dout=%h wait=%b rd=%b required %h 0 0",
               cpu_dout, cpu_wait, mem_rd, m_dout);
    end
    cpu_rd = 1'b0;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic test_download();
    int rdcnt;
    @(negedge clk_sys);
    cpu_addr = 16'h0200; cpu_rd = 1'b1;
    @(negedge clk_sys);
    cart_download = 1'b1;
    c_vld = 1'b0;
    @(negedge clk_sys);
    n_cmp++;
    if (mem_rd !== 1'b0 || cpu_wait !== 1'b0) begin
      n_fail++;
      $display("FAIL download_abort: got rd=%b wait=%b required 0 0", mem_rd, cpu_wait);
    end
    cpu_rd = 1'b0;
    @(negedge clk_sys);
    cpu_addr = 16'hC000; cpu_rd = 1'b1;
    rdcnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_sys);
      if (mem_rd || cpu_wait) rdcnt++;
    end
    m_dout = 8'hFF;
    n_cmp++;
    if (rdcnt !== 0 || cpu_dout !== 8'hFF) begin
      n_fail++;
      $display("FAIL download_read: got busy_cycles=%0d dout=%h required 0 FF", rdcnt, cpu_dout);
    end
    cpu_rd = 1'b0;
    cart_download = 1'b0;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic test_reset_mid_fetch();
    int busy;
    @(negedge clk_sys);
    cpu_addr = 16'hC010; cpu_rd = 1'b1;
    @(negedge clk_sys);
    n_cmp++;
    if (mem_rd !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_req_start: got rd=%b required 1", mem_rd);
    end
    reset_n = 1'b0; cpu_rd = 1'b0;
    model_reset();
    @(negedge clk_sys);
    reset_n = 1'b1;
    mem_ack = 1'b1; mem_q = 8'h33;
    @(negedge clk_sys);
    mem_ack = 1'b0;
    busy = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_sys);
      if (mem_rd || cpu_wait) busy++;
    end
    n_cmp++;
    if (busy !== 0 || {cpu_dout, mem_addr, bank_sel, timeout_err} !== {8'hFF, 19'd0, 5'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_fetch: got busy=%0d dout=%h addr=%h bank=%h terr=%b required 0 FF 00000 00 0",
               busy, cpu_dout, mem_addr, bank_sel, timeout_err);
    end
  endtask

  task automatic test_cache_sequence();
    do_read(16'hC123, 2, 8'h77);
    do_read(16'hC123, 2, 8'h78);
    @(negedge clk_sys);
    cart_download = 1'b1;
    c_vld = 1'b0;
    @(negedge clk_sys);
    cart_download = 1'b0;
    do_read(16'hC123, 1, 8'h79);
  endtask

  task automatic test_random();
    logic [15:0] a;
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 5))
        0: a = 16'hC123;
        1: a = 16'h0010;
        2: a = {2'b00, 14'($urandom)};
        3: a = {2'b11, 14'($urandom)};
        4: a = {2'b01 + 2'($urandom_range(0, 1)), 14'($urandom)};
        default: a = 16'hC123;
      endcase
      if ($urandom_range(0, 4) == 0)
        bank_write({8'hDF, 8'($urandom)}, 8'($urandom));
      do_read(a, $urandom_range(0, TO + 1), 8'($urandom));
    end
  endtask

  initial begin
    test_reset();
    bank_write(16'hDF00, 8'h05);
    do_read(16'hC123, 3, 8'h5A);       // expect mem_addr 0x14123, 4 wait cycles
    bank_write(16'hDE00, 8'h1F);       // not a bank register
    do_read(16'h0010, TO + 4, 8'h00);  // timeout
    do_read(16'h8000, 0, 8'h11);       // unmapped
    do_read(16'h0020, TO - 1, 8'h42);  // ack on the timeout cycle
    do_read(16'h0030, 0, 8'hA5);       // immediate ack
    test_write_during_fetch();
    test_download();
    test_cache_sequence();
    test_random();
    test_reset_mid_fetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
